mips_multicycle_control: RTL and testbench

// - Moore FSM sequencing the multicycle MIPS datapath; sits directly upstream of the unified memory system.
// - Drives its write enable (mem_write_o) and the PC/ALUOut address select (iord_o).
// - Consumes opcode/funct from the instruction register loaded from memory output; includes ALU decoder.

---
 rtl/mips_multicycle_control_if.sv | 31 +++
 rtl/mips_multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath / unified memory.
// The master side is the controller; the slave side is the datapath that obeys it.
interface mips_multicycle_control_if #(parameter int STATE_WIDTH = 4);
  logic [5:0]             opcode_i;
  logic [5:0]             funct_i;
  logic                   zero_i;
  logic                   iord_o;
  logic                   mem_write_o;
  logic                   ir_write_o;
  logic                   reg_dst_o;
  logic                   mem_to_reg_o;
  logic                   reg_write_o;
  logic                   alu_src_a_o;
  logic [1:0]             alu_src_b_o;
  logic [2:0]             alu_control_o;
  logic [1:0]             pc_src_o;
  logic                   pc_en_o;
  logic [STATE_WIDTH-1:0] state_o;

  modport master (
    input  opcode_i, funct_i, zero_i,
    output iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_control_o, pc_src_o, pc_en_o, state_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i,
    input  iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_control_o, pc_src_o, pc_en_o, state_o
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore controller for the multicycle MIPS datapath, with its ALU decoder.
// Optional feature: define MIPS_CTRL_BNE_EN to add the bne instruction (state 12).
module mips_multicycle_control #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  mips_multicycle_control_if.master  dp
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH    = 0,
    DECODE   = 1,
    MEMADR   = 2,
    MEMREAD  = 3,
    MEMWB    = 4,
    MEMWRITE = 5,
    EXECUTE  = 6,
    ALUWB    = 7,
    BRANCH   = 8,
    ADDIEX   = 9,
    ADDIWB   = 10,
    JUMP     = 11,
    BNE      = 12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  function automatic logic [2:0] alu_decode(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      6'h20:   op = 3'b010;
      6'h22:   op = 3'b110;
      6'h24:   op = 3'b000;
      6'h25:   op = 3'b001;
      6'h2A:   op = 3'b111;
      default: op = 3'b010;
    endcase
    return op;
  endfunction

  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] funct);
    ctrl_t c;
    c             = '0;
    c.alu_control = 3'b010;
    case (s)
      FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      DECODE:   c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMREAD:  c.iord = 1'b1;
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = alu_decode(funct);
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = 3'b110;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      BNE: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = 3'b110;
        c.pc_src      = 2'b01;
        c.branch_ne   = 1'b1;
      end
`endif
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB:   c.reg_write = 1'b1;
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] opcode);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (opcode)
          6'h23, 6'h2B: n = MEMADR;
          6'h00:        n = EXECUTE;
          6'h04:        n = BRANCH;
          6'h08:        n = ADDIEX;
          6'h02:        n = JUMP;
`ifdef MIPS_CTRL_BNE_EN
          6'h05:        n = BNE;
`endif
          default:      n = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == 6'h23)      n = MEMREAD;
        else if (opcode == 6'h2B) n = MEMWRITE;
        else                      n = FETCH;
      end
      MEMREAD: n = MEMWB;
      EXECUTE: n = ALUWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  assign state_next = next_state(state, dp.opcode_i);

  // Outputs are precomputed for the state being entered, so they are registered yet Moore-exact.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= FETCH;
      ctrl  <= ctrl_for(FETCH, 6'h00);
    end else begin
      state <= state_next;
      ctrl  <= ctrl_for(state_next, dp.funct_i);
    end
  end

  // Reset masks everything at once, so an aborted instruction cannot leave a write enable high.
  assign dp.iord_o        = rst_n_i & ctrl.iord;
  assign dp.mem_write_o   = rst_n_i & ctrl.mem_write;
  assign dp.ir_write_o    = rst_n_i & ctrl.ir_write;
  assign dp.reg_dst_o     = rst_n_i & ctrl.reg_dst;
  assign dp.mem_to_reg_o  = rst_n_i & ctrl.mem_to_reg;
  assign dp.reg_write_o   = rst_n_i & ctrl.reg_write;
  assign dp.alu_src_a_o   = rst_n_i & ctrl.alu_src_a;
  assign dp.alu_src_b_o   = rst_n_i ? ctrl.alu_src_b   : 2'b00;
  assign dp.alu_control_o = rst_n_i ? ctrl.alu_control : 3'b010;
  assign dp.pc_src_o      = rst_n_i ? ctrl.pc_src      : 2'b00;
  assign dp.pc_en_o       = rst_n_i & (ctrl.pc_write
                                       | (ctrl.branch & dp.zero_i)
                                       | (ctrl.branch_ne & ~dp.zero_i));
  assign dp.state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control; each task walks one instruction class.
// Honors MIPS_CTRL_BNE_EN the same way the design does.
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_multicycle_control_if #(.STATE_WIDTH(4)) bus_if ();

  mips_multicycle_control #(.STATE_WIDTH(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .dp      (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus_if.opcode_i = 6'h00;
    bus_if.funct_i  = 6'h00;
    bus_if.zero_i   = 1'b0;
    #22;
    checks++;
    if (bus_if.state_o !== 4'd0 || bus_if.ir_write_o !== 1'b0 || bus_if.pc_en_o !== 1'b0 ||
        bus_if.mem_write_o !== 1'b0 || bus_if.reg_write_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: state=%0d irw=%b pcen=%b memw=%b regw=%b, expected 0 0 0 0 0",
               bus_if.state_o, bus_if.ir_write_o, bus_if.pc_en_o, bus_if.mem_write_o, bus_if.reg_write_o);
    end
    checks++;
    if (bus_if.alu_control_o !== 3'b010 || bus_if.alu_src_b_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_alu: aluctl=%b srcb=%b, expected 010 00",
               bus_if.alu_control_o, bus_if.alu_src_b_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.state_o !== 4'd0 || bus_if.ir_write_o !== 1'b1 || bus_if.pc_en_o !== 1'b1 ||
        bus_if.alu_src_b_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release: state=%0d irw=%b pcen=%b srcb=%b, expected 0 1 1 01",
               bus_if.state_o, bus_if.ir_write_o, bus_if.pc_en_o, bus_if.alu_src_b_o);
    end
    tick();
    checks++;
    if (bus_if.state_o !== 4'd1 || bus_if.alu_src_b_o !== 2'b11 || bus_if.pc_en_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_decode: state=%0d srcb=%b pcen=%b, expected 1 11 0",
               bus_if.state_o, bus_if.alu_src_b_o, bus_if.pc_en_o);
    end
    bus_if.opcode_i = 6'h3F;
    tick();
  endtask

  task automatic test_lw();
    logic [3:0] exp_state [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       exp_rw    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_iord  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus_if.opcode_i = 6'h23;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_if.state_o !== exp_state[i] || bus_if.reg_write_o !== exp_rw[i] ||
          bus_if.mem_write_o !== 1'b0 || bus_if.iord_o !== exp_iord[i]) begin
        errors++;
        $display("[TB] FAIL lw step %0d: state=%0d regw=%b memw=%b iord=%b, expected %0d %b 0 %b",
                 i, bus_if.state_o, bus_if.reg_write_o, bus_if.mem_write_o, bus_if.iord_o,
                 exp_state[i], exp_rw[i], exp_iord[i]);
      end
      if (i == 4) begin
        checks++;
        if (bus_if.mem_to_reg_o !== 1'b1 || bus_if.reg_dst_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL lw_memwb: memtoreg=%b regdst=%b, expected 1 0",
                   bus_if.mem_to_reg_o, bus_if.reg_dst_o);
        end
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_state [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic       exp_mw    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus_if.opcode_i = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_if.state_o !== exp_state[i] || bus_if.mem_write_o !== exp_mw[i] ||
          bus_if.iord_o !== exp_mw[i] || bus_if.reg_write_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sw step %0d: state=%0d memw=%b iord=%b regw=%b, expected %0d %b %b 0",
                 i, bus_if.state_o, bus_if.mem_write_o, bus_if.iord_o, bus_if.reg_write_o,
                 exp_state[i], exp_mw[i], exp_mw[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] functs  [3] = '{6'h22, 6'h2A, 6'h25};
    logic [2:0] exp_alu [3] = '{3'b110, 3'b111, 3'b001};
    bus_if.opcode_i = 6'h00;
    for (int k = 0; k < 3; k++) begin
      bus_if.funct_i = functs[k];
      tick();
      tick();
      checks++;
      if (bus_if.state_o !== 4'd6 || bus_if.alu_control_o !== exp_alu[k] ||
          bus_if.alu_src_a_o !== 1'b1 || bus_if.alu_src_b_o !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rtype_exec funct=%h: state=%0d aluctl=%b srca=%b srcb=%b, expected 6 %b 1 00",
                 functs[k], bus_if.state_o, bus_if.alu_control_o, bus_if.alu_src_a_o,
                 bus_if.alu_src_b_o, exp_alu[k]);
      end
      tick();
      checks++;
      if (bus_if.state_o !== 4'd7 || bus_if.reg_dst_o !== 1'b1 || bus_if.reg_write_o !== 1'b1 ||
          bus_if.mem_to_reg_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rtype_wb funct=%h: state=%0d regdst=%b regw=%b memtoreg=%b, expected 7 1 1 0",
                 functs[k], bus_if.state_o, bus_if.reg_dst_o, bus_if.reg_write_o, bus_if.mem_to_reg_o);
      end
      tick();
      checks++;
      if (bus_if.state_o !== 4'd0) begin
        errors++;
        $display("[TB] FAIL rtype_return: state=%0d expected 0", bus_if.state_o);
      end
    end
  endtask

  task automatic test_branch();
    bus_if.opcode_i = 6'h04;
    for (int z = 1; z >= 0; z--) begin
      bus_if.zero_i = z[0];
      tick();
      tick();
      checks++;
      if (bus_if.state_o !== 4'd8 || bus_if.pc_en_o !== z[0] || bus_if.pc_src_o !== 2'b01 ||
          bus_if.alu_control_o !== 3'b110) begin
        errors++;
        $display("[TB] FAIL beq zero=%0d: state=%0d pcen=%b pcsrc=%b aluctl=%b, expected 8 %b 01 110",
                 z, bus_if.state_o, bus_if.pc_en_o, bus_if.pc_src_o, bus_if.alu_control_o, z[0]);
      end
      tick();
      checks++;
      if (bus_if.state_o !== 4'd0 || bus_if.pc_en_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL beq_return zero=%0d: state=%0d pcen=%b, expected 0 1",
                 z, bus_if.state_o, bus_if.pc_en_o);
      end
    end
    bus_if.zero_i = 1'b0;
  endtask

  task automatic test_addi_jump();
    bus_if.opcode_i = 6'h08;
    tick();
    tick();
    checks++;
    if (bus_if.state_o !== 4'd9 || bus_if.alu_src_b_o !== 2'b10 || bus_if.reg_write_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addi_ex: state=%0d srcb=%b regw=%b, expected 9 10 0",
               bus_if.state_o, bus_if.alu_src_b_o, bus_if.reg_write_o);
    end
    tick();
    checks++;
    if (bus_if.state_o !== 4'd10 || bus_if.reg_write_o !== 1'b1 || bus_if.reg_dst_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addi_wb: state=%0d regw=%b regdst=%b, expected 10 1 0",
               bus_if.state_o, bus_if.reg_write_o, bus_if.reg_dst_o);
    end
    tick();
    bus_if.opcode_i = 6'h02;
    tick();
    tick();
    checks++;
    if (bus_if.state_o !== 4'd11 || bus_if.pc_en_o !== 1'b1 || bus_if.pc_src_o !== 2'b10) begin
      errors++;
      $display("[TB] FAIL jump: state=%0d pcen=%b pcsrc=%b, expected 11 1 10",
               bus_if.state_o, bus_if.pc_en_o, bus_if.pc_src_o);
    end
    tick();
    checks++;
    if (bus_if.state_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL jump_return: state=%0d expected 0", bus_if.state_o);
    end
  endtask

  task automatic test_unknown_and_bne();
    bus_if.opcode_i = 6'h3F;
    tick();
    tick();
    checks++;
    if (bus_if.state_o !== 4'd0 || bus_if.ir_write_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unknown_op: state=%0d irw=%b, expected 0 1",
               bus_if.state_o, bus_if.ir_write_o);
    end
    bus_if.opcode_i = 6'h05;
    bus_if.zero_i   = 1'b0;
    tick();
    tick();
`ifdef MIPS_CTRL_BNE_EN
    checks++;
    if (bus_if.state_o !== 4'd12 || bus_if.pc_en_o !== 1'b1 || bus_if.pc_src_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bne: state=%0d pcen=%b pcsrc=%b, expected 12 1 01",
               bus_if.state_o, bus_if.pc_en_o, bus_if.pc_src_o);
    end
    bus_if.zero_i = 1'b1;
    #1;
    checks++;
    if (bus_if.pc_en_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bne_taken_zero: pcen=%b expected 0", bus_if.pc_en_o);
    end
    bus_if.zero_i = 1'b0;
    tick();
`endif
    checks++;
    if (bus_if.state_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL op05_return: state=%0d expected 0", bus_if.state_o);
    end
  endtask

  task automatic test_reset_mid_execute();
    bus_if.opcode_i = 6'h00;
    bus_if.funct_i  = 6'h22;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.state_o !== 4'd0 || bus_if.alu_control_o !== 3'b010 || bus_if.alu_src_a_o !== 1'b0 ||
        bus_if.reg_write_o !== 1'b0 || bus_if.pc_en_o !== 1'b0 || bus_if.ir_write_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: state=%0d aluctl=%b srca=%b regw=%b pcen=%b irw=%b, expected 0 010 0 0 0 0",
               bus_if.state_o, bus_if.alu_control_o, bus_if.alu_src_a_o, bus_if.reg_write_o,
               bus_if.pc_en_o, bus_if.ir_write_o);
    end
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.state_o !== 4'd0 || bus_if.ir_write_o !== 1'b1 || bus_if.pc_en_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_release: state=%0d irw=%b pcen=%b, expected 0 1 1",
               bus_if.state_o, bus_if.ir_write_o, bus_if.pc_en_o);
    end
    bus_if.opcode_i = 6'h3F;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int cycles;
    int mw_pulses;
    cycles    = 0;
    mw_pulses = 0;
    bus_if.opcode_i = 6'h23;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.mem_write_o === 1'b1) mw_pulses++;
      tick();
      cycles++;
    end
    bus_if.opcode_i = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      if (bus_if.mem_write_o === 1'b1) mw_pulses++;
      tick();
      cycles++;
    end
    checks++;
    if (mw_pulses != 1 || bus_if.state_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL back_to_back: memw pulses=%0d state=%0d after %0d cycles, expected 1 0",
               mw_pulses, bus_if.state_o, cycles);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_branch();
    test_addi_jump();
    test_unknown_and_bne();
    test_reset_mid_execute();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
